mem_port_arbiter: RTL and testbench

- Shares one single-ported unified memory between the instruction-fetch path and the data-memory path of the MIPS pipeline.
- Grants one requester at a time and holds the memory request until the memory acknowledges.
- Returns read data to the granted side, and generates stall signals that hold the PC register and insert nops while fetch waits.
- Data accesses have priority; a starvation counter guarantees fetch forward progress.

---
 rtl/mem_port_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported unified memory between MIPS instruction
// fetch and data access. Data has priority; a starvation counter forces fetch through.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_W-1:0]     if_rdata,
  output logic                  if_valid,
  output logic                  if_stall,
  input  logic                  dm_re,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_W-1:0]     dm_wdata,
  input  logic [1:0]            dm_size,
  output logic [DATA_W-1:0]     dm_rdata,
  output logic                  dm_valid,
  output logic                  dm_stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [1:0]            mem_size,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ack
);

  typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY} state_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e                  state_q;
  logic [3:0]              starveCnt_q;
  logic [3:0]              starveCnt_d;
  logic                    memReq_q;
  logic                    memWe_q;
  logic [ADDR_WIDTH-1:0]   memAddr_q;
  logic [DATA_W-1:0]       memWdata_q;
  logic [1:0]              memSize_q;
  logic [DATA_W-1:0]       ifRdata_q;
  logic [DATA_W-1:0]       dmRdata_q;
  logic                    ifValid_q;
  logic                    dmValid_q;
  logic                    dmReq;
  logic                    dmWins;

  assign dmReq  = dm_re | dm_we;
  assign dmWins = dmReq & (~if_req | (starveCnt_q < LIMIT));

  // Counts data wins that bypassed a waiting fetch, saturating at the counter width.
  always_comb begin
    starveCnt_d = 4'd0;
    if (if_req) begin
      starveCnt_d = (starveCnt_q == 4'hF) ? starveCnt_q : starveCnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      starveCnt_q <= 4'd0;
      memReq_q    <= 1'b0;
      memWe_q     <= 1'b0;
      memAddr_q   <= '0;
      memWdata_q  <= '0;
      memSize_q   <= 2'b00;
      ifRdata_q   <= '0;
      dmRdata_q   <= '0;
      ifValid_q   <= 1'b0;
      dmValid_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ifValid_q <= 1'b0;
          dmValid_q <= 1'b0;
          if (dmWins) begin
            state_q     <= DM_BUSY;
            starveCnt_q <= starveCnt_d;
            memReq_q    <= 1'b1;
            memWe_q     <= dm_we;
            memAddr_q   <= dm_addr;
            memWdata_q  <= dm_wdata;
            memSize_q   <= dm_size;
          end else if (if_req) begin
            state_q     <= IF_BUSY;
            starveCnt_q <= 4'd0;
            memReq_q    <= 1'b1;
            memWe_q     <= 1'b0;
            memAddr_q   <= if_addr;
            memSize_q   <= 2'b10;
          end
        end
        IF_BUSY: begin
          if (mem_ack) begin
            state_q   <= IDLE;
            memReq_q  <= 1'b0;
            memWe_q   <= 1'b0;
            ifRdata_q <= mem_rdata;
            ifValid_q <= 1'b1;
          end
        end
        DM_BUSY: begin
          if (mem_ack) begin
            state_q   <= IDLE;
            memReq_q  <= 1'b0;
            memWe_q   <= 1'b0;
            if (!memWe_q) begin
              dmRdata_q <= mem_rdata;
            end
            dmValid_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= IDLE;
          memReq_q <= 1'b0;
          memWe_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req   = memReq_q;
  assign mem_we    = memWe_q;
  assign mem_addr  = memAddr_q;
  assign mem_wdata = memWdata_q;
  assign mem_size  = memSize_q;
  assign if_rdata  = ifRdata_q;
  assign if_valid  = ifValid_q;
  assign dm_rdata  = dmRdata_q;
  assign dm_valid  = dmValid_q;

  assign if_stall = if_req & ~ifValid_q;
  assign dm_stall = dmReq & ~dmValid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: the bench plays the memory and both
// requesters, driving and sampling on the falling clock edge.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [9:0]  if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        if_stall;
  logic        dm_re;
  logic        dm_we;
  logic [9:0]  dm_addr;
  logic [31:0] dm_wdata;
  logic [1:0]  dm_size;
  logic [31:0] dm_rdata;
  logic        dm_valid;
  logic        dm_stall;
  logic        mem_req;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_size;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int checkCount;
  int passCount;

  mem_port_arbiter #(.ADDR_WIDTH(10), .DATA_W(32), .STARVE_LIMIT(3)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_valid(if_valid), .if_stall(if_stall),
    .dm_re(dm_re), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_size(dm_size), .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_size(mem_size), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  // Waits a bounded number of cycles for the arbiter to raise mem_req.
  task automatic waitMemReq(input string tag);
    int n;
    n = 0;
    while (mem_req !== 1'b1 && n < 10) begin
      applyStimulus(1);
      n++;
    end
    checkOutput(tag, {31'd0, mem_req}, 32'd1);
  endtask

  // Pulses mem_ack for one cycle with the given read data.
  task automatic ackMemory(input logic [31:0] rdata);
    mem_ack   = 1'b1;
    mem_rdata = rdata;
    applyStimulus(1);
    mem_ack   = 1'b0;
  endtask

  initial begin
    logic expWrite[5];
    checkCount = 0;
    passCount  = 0;
    reset = 1'b1; if_req = 1'b0; if_addr = '0; dm_re = 1'b0; dm_we = 1'b0;
    dm_addr = '0; dm_wdata = '0; dm_size = 2'b00; mem_rdata = 32'hFFFF_FFFF; mem_ack = 1'b1;

    // Reset held for two cycles with a stray ack present.
    applyStimulus(2);
    checkOutput("rst mem_req",  {31'd0, mem_req}, 32'd0);
    checkOutput("rst mem_we",   {31'd0, mem_we}, 32'd0);
    checkOutput("rst if_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("rst dm_valid", {31'd0, dm_valid}, 32'd0);
    checkOutput("rst mem_addr", {22'd0, mem_addr}, 32'd0);
    checkOutput("rst mem_wdata", mem_wdata, 32'd0);
    checkOutput("rst mem_size", {30'd0, mem_size}, 32'd0);
    checkOutput("rst if_rdata", if_rdata, 32'd0);
    checkOutput("rst dm_rdata", dm_rdata, 32'd0);
    reset = 1'b0; mem_ack = 1'b0;
    applyStimulus(1);
    checkOutput("idle ack no if_valid", {31'd0, if_valid}, 32'd0);

    // Single fetch, ack two cycles after mem_req rises.
    if_req = 1'b1; if_addr = 10'h004;
    #1 checkOutput("fetch stall early", {31'd0, if_stall}, 32'd1);
    applyStimulus(1);
    checkOutput("fetch mem_req c1", {31'd0, mem_req}, 32'd1);
    checkOutput("fetch mem_addr", {22'd0, mem_addr}, 32'h004);
    checkOutput("fetch mem_size", {30'd0, mem_size}, 32'd2);
    checkOutput("fetch mem_we", {31'd0, mem_we}, 32'd0);
    applyStimulus(1);
    checkOutput("fetch mem_req c2", {31'd0, mem_req}, 32'd1);
    checkOutput("fetch stall busy", {31'd0, if_stall}, 32'd1);
    ackMemory(32'h3400_0000);
    checkOutput("fetch if_valid", {31'd0, if_valid}, 32'd1);
    checkOutput("fetch if_rdata", if_rdata, 32'h3400_0000);
    checkOutput("fetch mem_req drop", {31'd0, mem_req}, 32'd0);
    checkOutput("fetch stall done", {31'd0, if_stall}, 32'd0);
    if_req = 1'b0;
    applyStimulus(1);
    checkOutput("fetch if_valid pulse", {31'd0, if_valid}, 32'd0);
    checkOutput("fetch no regrant", {31'd0, mem_req}, 32'd0);

    // Simultaneous fetch and data read: data first, then fetch.
    if_req = 1'b1; if_addr = 10'h020;
    dm_re = 1'b1; dm_addr = 10'h010; dm_size = 2'b10;
    applyStimulus(1);
    checkOutput("sim dm mem_addr", {22'd0, mem_addr}, 32'h010);
    checkOutput("sim dm mem_we", {31'd0, mem_we}, 32'd0);
    checkOutput("sim if_stall a", {31'd0, if_stall}, 32'd1);
    checkOutput("sim dm_stall", {31'd0, dm_stall}, 32'd1);
    ackMemory(32'hA5A5_0001);
    checkOutput("sim dm_valid", {31'd0, dm_valid}, 32'd1);
    checkOutput("sim dm_rdata", dm_rdata, 32'hA5A5_0001);
    checkOutput("sim no if_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("sim if_stall b", {31'd0, if_stall}, 32'd1);
    dm_re = 1'b0;
    applyStimulus(1);
    checkOutput("sim if mem_req", {31'd0, mem_req}, 32'd1);
    checkOutput("sim if mem_addr", {22'd0, mem_addr}, 32'h020);
    checkOutput("sim if_stall c", {31'd0, if_stall}, 32'd1);
    ackMemory(32'h1111_2222);
    checkOutput("sim if_valid", {31'd0, if_valid}, 32'd1);
    checkOutput("sim if_rdata", if_rdata, 32'h1111_2222);
    if_req = 1'b0;

    // Write pass-through; dm_rdata must keep the earlier load value.
    applyStimulus(1);
    dm_we = 1'b1; dm_addr = 10'h3FF; dm_wdata = 32'hDEAD_BEEF; dm_size = 2'b01;
    applyStimulus(1);
    checkOutput("wr mem_we", {31'd0, mem_we}, 32'd1);
    checkOutput("wr mem_addr", {22'd0, mem_addr}, 32'h3FF);
    checkOutput("wr mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    checkOutput("wr mem_size", {30'd0, mem_size}, 32'd1);
    ackMemory(32'h1234_5678);
    checkOutput("wr dm_valid", {31'd0, dm_valid}, 32'd1);
    checkOutput("wr dm_rdata kept", dm_rdata, 32'hA5A5_0001);
    checkOutput("wr mem_we drop", {31'd0, mem_we}, 32'd0);
    dm_we = 1'b0;
    applyStimulus(1);
    checkOutput("wr dm_valid pulse", {31'd0, dm_valid}, 32'd0);

    // Starvation: fetch pending, data writes continuous -> W W W F W.
    expWrite[0] = 1'b1; expWrite[1] = 1'b1; expWrite[2] = 1'b1;
    expWrite[3] = 1'b0; expWrite[4] = 1'b1;
    if_req = 1'b1; if_addr = 10'h040;
    dm_we = 1'b1; dm_addr = 10'h100; dm_wdata = 32'h0000_0055; dm_size = 2'b10;
    for (int i = 0; i < 5; i++) begin
      waitMemReq($sformatf("starve req %0d", i));
      checkOutput($sformatf("starve kind %0d", i), {31'd0, mem_we}, {31'd0, expWrite[i]});
      ackMemory(32'h0000_0100 + i);
      if (expWrite[i]) begin
        checkOutput($sformatf("starve dm_valid %0d", i), {31'd0, dm_valid}, 32'd1);
      end else begin
        checkOutput($sformatf("starve if_valid %0d", i), {31'd0, if_valid}, 32'd1);
        checkOutput("starve if_rdata", if_rdata, 32'h0000_0103);
      end
      if (i == 4) begin
        dm_we = 1'b0; if_req = 1'b0;
      end
    end
    applyStimulus(1);
    checkOutput("starve quiet", {31'd0, mem_req}, 32'd0);

    // Fetch address changes while busy; latched address must hold.
    if_req = 1'b1; if_addr = 10'h008;
    applyStimulus(1);
    checkOutput("hold addr a", {22'd0, mem_addr}, 32'h008);
    if_addr = 10'h00C;
    applyStimulus(1);
    checkOutput("hold addr b", {22'd0, mem_addr}, 32'h008);
    checkOutput("hold mem_req", {31'd0, mem_req}, 32'd1);
    ackMemory(32'hCAFE_0008);
    checkOutput("hold if_rdata", if_rdata, 32'hCAFE_0008);
    if_req = 1'b0;
    applyStimulus(1);
    mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    applyStimulus(1);
    mem_ack = 1'b0;
    checkOutput("spurious if_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("spurious dm_valid", {31'd0, dm_valid}, 32'd0);
    checkOutput("spurious if_rdata", if_rdata, 32'hCAFE_0008);

    // Reset during IF_BUSY, then a late ack must be ignored.
    if_req = 1'b1; if_addr = 10'h050;
    applyStimulus(1);
    checkOutput("abort mem_req up", {31'd0, mem_req}, 32'd1);
    reset = 1'b1;
    applyStimulus(1);
    checkOutput("abort mem_req down", {31'd0, mem_req}, 32'd0);
    reset = 1'b0; if_req = 1'b0;
    ackMemory(32'h9999_9999);
    checkOutput("abort no if_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("abort if_rdata", if_rdata, 32'd0);
    applyStimulus(1);
    checkOutput("abort idle", {31'd0, mem_req}, 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
